// File: rtl/block_sequencer.sv
// block_sequencer
//   Splits a host transfer of up to 65536 words into 256-word device blocks. For each block it
//   waits until the host FIFO can source/sink the words it needs, hands a read or write command
//   to the device, then counts the device data enables until the device reports ready again.
//
// Configuration macro:
//   BOUNDS_CHECK_EN  when defined, a request whose last block lies past MAX_BLOCKS is rejected
//                    with error=1 before any command is issued.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge) and asynchronous active-low reset
//   start_i                request strobe, sampled only when idle
//   write_i                direction: 1 = host-to-disk, 0 = disk-to-host
//   start_block_i          first block number
//   word_count_i           transfer length in words, 0 means 65536
//   abort_i                stop after the block in progress
//   busy_o, done_o         transfer active / one-cycle completion pulse
//   error_o                valid with done_o, held until the next accepted start
//   wfifo_level_i          words held in the host write FIFO
//   rfifo_free_i           free slots in the host read FIFO
//   host_rd_en_o           pop of the host write FIFO (combinational)
//   host_wr_en_o           push to the host read FIFO (combinational)
//   pad_sel_o              registered; selects zero padding on the device write data
//   device_ready_i         device idle / ready for a command
//   read_cmd_o, write_cmd_o  device commands, held until device_ready_i drops
//   block_address_o        block addressed by the current command
//   write_data_enable_i    device consumes one write word
//   read_data_enable_i     device produces one read word
module block_sequencer #(
   parameter int unsigned MAX_BLOCKS = 120,
   parameter int unsigned BLOCK_SIZE = 256
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        write_i,
   input  logic [31:0] start_block_i,
   input  logic [15:0] word_count_i,
   input  logic        abort_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o,
   input  logic [9:0]  wfifo_level_i,
   input  logic [9:0]  rfifo_free_i,
   output logic        host_rd_en_o,
   output logic        host_wr_en_o,
   output logic        pad_sel_o,
   input  logic        device_ready_i,
   output logic        read_cmd_o,
   output logic        write_cmd_o,
   output logic [31:0] block_address_o,
   input  logic        write_data_enable_i,
   input  logic        read_data_enable_i
);

   localparam logic [8:0] BlkWords = 9'(BLOCK_SIZE);

`ifdef BOUNDS_CHECK_EN
   localparam logic BoundsEn = 1'b1;
`else
   localparam logic BoundsEn = 1'b0;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StWaitFifo,
      StIssue,
      StWaitAccept,
      StWaitDone,
      StFinish
   } state_e;

   state_e      state_q, state_d;
   logic        write_q, write_d;
   logic [16:0] remaining_q, remaining_d;
   logic [31:0] block_address_q, block_address_d;
   logic [8:0]  blk_words_q, blk_words_d;
   logic        cmd_q, cmd_d;
   logic        error_q, error_d;
   logic        abort_seen_q, abort_seen_d;
   logic        pad_sel_q, pad_sel_d;

   logic        busy;
   logic [8:0]  need;
   logic        in_block;
   logic        fifo_ok;
   logic        data_en;
   logic        abort_pend;
   logic [8:0]  blocks_needed;
   logic [32:0] end_block;
   logic        out_of_bounds;

   assign busy       = (state_q != StIdle);
   assign need       = (remaining_q >= 17'(BlkWords)) ? BlkWords : remaining_q[8:0];
   assign in_block   = (blk_words_q < need);
   assign fifo_ok    = write_q ? (wfifo_level_i >= {1'b0, need})
                               : (rfifo_free_i >= {1'b0, need});
   assign data_en    = write_q ? write_data_enable_i : read_data_enable_i;
   assign abort_pend = abort_seen_q | abort_i;

   // ceil(remaining / 256); the sum is 33 bits wide so a start block near 2^32 cannot wrap
   assign blocks_needed = 9'((remaining_q + 17'd255) >> 8);
   assign end_block     = {1'b0, block_address_q} + 33'(blocks_needed);
   assign out_of_bounds = (end_block > 33'(MAX_BLOCKS));

   // Words past need are still counted so the device sees a full block: writes get zero
   // padding, reads are dropped.
   assign host_rd_en_o = write_data_enable_i & busy & write_q & in_block;
   assign host_wr_en_o = read_data_enable_i & busy & ~write_q & in_block;

   assign busy_o          = busy;
   assign done_o          = (state_q == StFinish);
   assign error_o         = error_q;
   assign pad_sel_o       = pad_sel_q;
   assign read_cmd_o      = cmd_q & ~write_q;
   assign write_cmd_o     = cmd_q & write_q;
   assign block_address_o = block_address_q;

   always_comb begin
      blk_words_d = blk_words_q;
      if (state_q == StIssue) begin
         blk_words_d = '0;
      end else if (busy && data_en && (blk_words_q != 9'h1FF)) begin
         blk_words_d = blk_words_q + 9'd1;
      end
      pad_sel_d = write_data_enable_i & busy & write_q & ~in_block;
   end

   always_comb begin
      state_d         = state_q;
      write_d         = write_q;
      remaining_d     = remaining_q;
      block_address_d = block_address_q;
      cmd_d           = cmd_q;
      error_d         = error_q;
      abort_seen_d    = abort_seen_q | (busy & abort_i);

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               write_d         = write_i;
               remaining_d     = (word_count_i == 16'd0) ? 17'h10000 : {1'b0, word_count_i};
               block_address_d = start_block_i;
               error_d         = 1'b0;
               abort_seen_d    = 1'b0;
               state_d         = StCheck;
            end
         end
         StCheck: begin
            if (BoundsEn && out_of_bounds) begin
               error_d = 1'b1;
               state_d = StFinish;
            end else begin
               state_d = StWaitFifo;
            end
         end
         StWaitFifo: begin
            if (abort_pend) begin
               error_d = 1'b1;
               state_d = StFinish;
            end else if (fifo_ok) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            // abort takes priority so no command leaves once it has been seen
            if (abort_pend) begin
               error_d = 1'b1;
               state_d = StFinish;
            end else if (device_ready_i) begin
               cmd_d   = 1'b1;
               state_d = StWaitAccept;
            end
         end
         StWaitAccept: begin
            if (!device_ready_i) begin
               cmd_d   = 1'b0;
               state_d = StWaitDone;
            end
         end
         StWaitDone: begin
            if (device_ready_i) begin
               remaining_d     = remaining_q - 17'(need);
               block_address_d = block_address_q + 32'd1;
               if ((remaining_d == 17'd0) || abort_pend) begin
                  error_d = abort_pend;
                  state_d = StFinish;
               end else begin
                  state_d = StWaitFifo;
               end
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= StIdle;
         write_q         <= 1'b0;
         remaining_q     <= '0;
         block_address_q <= '0;
         blk_words_q     <= '0;
         cmd_q           <= 1'b0;
         error_q         <= 1'b0;
         abort_seen_q    <= 1'b0;
         pad_sel_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         write_q         <= write_d;
         remaining_q     <= remaining_d;
         block_address_q <= block_address_d;
         blk_words_q     <= blk_words_d;
         cmd_q           <= cmd_d;
         error_q         <= error_d;
         abort_seen_q    <= abort_seen_d;
         pad_sel_q       <= pad_sel_d;
      end
   end

endmodule

// File: doc/block_sequencer.md
BLOCK_SEQUENCER -- requirements
Module: block_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_BLOCKS, default 120, giving the number of blocks on the attached device.
REQ-002 The block SHALL have parameter BLOCK_SIZE, default 256, giving words per block; only 256 is supported.
REQ-003 Port clk  in  1  system clock, 20 MHz; all logic is on the rising edge.
REQ-004 Port reset  in  1  one clock; reset is asynchronous and active-low.
REQ-005 Port start  in  1  single-cycle request strobe; sampled only in IDLE.
REQ-006 Port write  in  1  request direction: 1 = host-to-disk, 0 = disk-to-host; sampled with start.
REQ-007 Port start_block  in  32  first block number; sampled with start.
REQ-008 Port word_count  in  16  transfer length in words; 0 means 65536; sampled with start.
REQ-009 Port abort  in  1  stop the transfer after the block in progress.
REQ-010 Port busy  out  1  high from the start acceptance cycle until done.
REQ-011 Port done  out  1  single-cycle completion pulse.
REQ-012 Port error  out  1  valid with done; held until the next accepted start.
REQ-013 Port wfifo_level  in  10  words held in the host write FIFO.
REQ-014 Port rfifo_free  in  10  free word slots in the host read FIFO.
REQ-015 Port host_rd_en  out  1  combinational pop of the host write FIFO.
REQ-016 Port host_wr_en  out  1  combinational push to the host read FIFO.
REQ-017 Port pad_sel  out  1  registered; when high, the write-data mux drives zeros to the device.
REQ-018 Device-side ports: device_ready in 1; read_cmd out 1; write_cmd out 1; block_address out 32; write_data_enable in 1; read_data_enable in 1.

Function
REQ-019 The block SHALL have the states IDLE, CHECK, WAIT_FIFO, ISSUE, WAIT_ACCEPT, WAIT_DONE and FINISH.
REQ-020 IDLE + start SHALL latch the request, set busy and load remaining = word_count (17 bits, 0 -> 65536) and block_address = start_block; the next state is CHECK.
REQ-021 WAIT_FIFO SHALL hold until need = min(256, remaining) satisfies wfifo_level >= need (write) or rfifo_free >= need (read), then go to ISSUE.
REQ-022 ISSUE SHALL wait for device_ready=1, then assert read_cmd or write_cmd and go to WAIT_ACCEPT.
REQ-023 The command SHALL stay asserted until device_ready is sampled low; it SHALL then drop, and the next state is WAIT_DONE.
REQ-024 block_address SHALL remain stable from ISSUE to the end of WAIT_DONE.
REQ-025 host_rd_en SHALL equal write_data_enable & busy & write & (blk_words < need); otherwise pad_sel SHALL be 1 on the following cycle.
REQ-026 host_wr_en SHALL equal read_data_enable & busy & !write & (blk_words < need); all read words past need SHALL be discarded.
REQ-027 blk_words (9 bits) SHALL count device enables per block and clear in ISSUE.
REQ-028 WAIT_DONE SHALL end when device_ready=1 after the command was accepted; then remaining -= need and block_address += 1.
REQ-029 At the end of WAIT_DONE, the next state SHALL be FINISH if remaining=0 or abort was seen, and WAIT_FIFO otherwise.
REQ-030 An abort seen in WAIT_FIFO or ISSUE before the command is asserted SHALL go to FINISH with no further command.
REQ-031 FINISH SHALL pulse done for 1 cycle, set error=abort_seen, clear busy and return to IDLE.
REQ-032 A start while busy SHALL be ignored.
REQ-033 A 65536-word transfer SHALL be exactly 256 blocks, and block_address SHALL wrap modulo 2^32.

Reset
REQ-034 Reset low SHALL force IDLE and set every output to 0: busy, done, error, read_cmd, write_cmd, pad_sel and block_address.
REQ-035 A reset during a transfer SHALL abandon it without a done pulse.

Configuration
REQ-036 With BOUNDS_CHECK_EN defined, CHECK SHALL go to FINISH with error=1 and no command when start_block + ceil(remaining/256) > MAX_BLOCKS, computed at 33-bit width.
REQ-037 Without BOUNDS_CHECK_EN, CHECK SHALL go directly to WAIT_FIFO, and error SHALL arise only from abort.

Verification
REQ-038 Write: start_block=0 and word_count=256 with wfifo_level=256 -> one write_cmd, 256 host_rd_en, pad_sel never high, done with error=0.
REQ-039 Read: start_block=1 and word_count=300 with rfifo_free=512 -> block_address 1 then 2, 300 host_wr_en, 212 words discarded, done.
REQ-040 Write: word_count=10 -> 10 host_rd_en, then pad_sel=1 for the remaining 246 enables.
REQ-041 With wfifo_level=100 and word_count=256 held, there SHALL be no write_cmd; raising wfifo_level to 256 -> write_cmd is issued.
REQ-042 Abort asserted mid-block in a 3-block read -> the current block completes, no second read_cmd is issued, and done pulses with error=1.
REQ-043 With BOUNDS_CHECK_EN, start_block=119 and word_count=512 -> done with error=1 and no read_cmd/write_cmd; reset mid-transfer -> all outputs 0 and no done.
